// File: rtl/pc_bus_host.sv
// Purpose: sole master sequencer for the 8-bit programmable counter. It loads
//          the counter (WRITE) or snapshots its count (READ) over a shared bus.
// Latency: WRITE rsp 5 cycles after accept, READ rsp READ_SETTLE+2 cycles;
//          cmd_ready is low for the whole command.
// Backpressure: one command in flight; cmd_ready = idle, cmd_valid ignored
//          while busy.
// Ports: clk/rst_n; run (free-run request); cmd_valid/cmd_ready/cmd_write/
//        cmd_data (command); rsp_valid/rsp_data (completion);
//        ctrl_en/ctrl_load/ctrl_oe (counter controls);
//        bus_out/bus_oe/bus_in (shared bus).
module pc_bus_host #(
   parameter int READ_SETTLE = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       run,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic       cmd_write,
   input  logic [7:0] cmd_data,
   output logic       rsp_valid,
   output logic [7:0] rsp_data,
   output logic       ctrl_en,
   output logic       ctrl_load,
   output logic       ctrl_oe,
   output logic [7:0] bus_out,
   output logic       bus_oe,
   input  logic [7:0] bus_in
);

   localparam logic [2:0] IDLE     = 3'd0;
   localparam logic [2:0] WR_LOAD  = 3'd1;
   localparam logic [2:0] WR_GAP   = 3'd2;
   localparam logic [2:0] WR_DRIVE = 3'd3;
   localparam logic [2:0] WR_DONE  = 3'd4;
   localparam logic [2:0] RD_WAIT  = 3'd5;
   localparam logic [2:0] RD_DONE  = 3'd6;

   localparam logic [3:0] SETTLE_LAST = 4'(READ_SETTLE);

   logic [2:0] state, state_nxt;
   logic [3:0] cnt, cnt_nxt;
   logic [7:0] data_q;

   assign cmd_ready = (state == IDLE);

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            if (cmd_valid) begin
               state_nxt = cmd_write ? WR_LOAD : RD_WAIT;
               cnt_nxt   = 4'd0;
            end
         end
         WR_LOAD: state_nxt = WR_GAP;
         WR_GAP: begin
            state_nxt = WR_DRIVE;
            cnt_nxt   = 4'd0;
         end
         // Host drives for two cycles so the counter's delayed capture
         // lands on the second one.
         WR_DRIVE: begin
            if (cnt == 4'd1) state_nxt = WR_DONE;
            else             cnt_nxt   = cnt + 4'd1;
         end
         WR_DONE: state_nxt = IDLE;
         // Counter is frozen but keeps driving; the first wait cycle lets an
         // already-registered increment finish before the sample.
         RD_WAIT: begin
            if (cnt == SETTLE_LAST) state_nxt = RD_DONE;
            else                    cnt_nxt   = cnt + 4'd1;
         end
         RD_DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs are decoded from the next state so each state's values are
   // visible in the same cycle the state is.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= 4'd0;
         data_q    <= 8'h00;
         ctrl_en   <= 1'b0;
         ctrl_load <= 1'b0;
         ctrl_oe   <= 1'b0;
         bus_oe    <= 1'b0;
         bus_out   <= 8'h00;
         rsp_valid <= 1'b0;
         rsp_data  <= 8'h00;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (cmd_valid && cmd_ready) data_q <= cmd_data;

         ctrl_en   <= (state_nxt == IDLE || state_nxt == WR_DONE ||
                       state_nxt == RD_DONE) ? run : 1'b0;
         ctrl_load <= (state_nxt == WR_LOAD);
         // Counter output is released from the load cycle through the drive
         // window so the bus has a turnaround gap on both sides.
         ctrl_oe   <= !(state_nxt == WR_LOAD || state_nxt == WR_GAP ||
                        state_nxt == WR_DRIVE);
         bus_oe    <= (state_nxt == WR_DRIVE);
         bus_out   <= (state_nxt == WR_DRIVE) ? data_q : 8'h00;
         rsp_valid <= (state_nxt == WR_DONE || state_nxt == RD_DONE);
         if (state_nxt == WR_DONE)      rsp_data <= data_q;
         else if (state_nxt == RD_DONE) rsp_data <= bus_in;
      end
   end

endmodule

// File: tb/tb_pc_bus_host.sv
// Purpose: directed self-checking bench for pc_bus_host with a behavioural
//          model of the 8-bit counter sharing the bus.
// Latency: checks are taken at the falling edge; inputs change there too.
// Backpressure: commands are only issued when cmd_ready is expected high.
module tb_pc_bus_host;

   localparam int S = 2;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       run;
   logic       cmd_valid;
   logic       cmd_ready;
   logic       cmd_write;
   logic [7:0] cmd_data;
   logic       rsp_valid;
   logic [7:0] rsp_data;
   logic       ctrl_en;
   logic       ctrl_load;
   logic       ctrl_oe;
   logic [7:0] bus_out;
   logic       bus_oe;
   logic [7:0] bus_in;

   int total = 0;
   int bad   = 0;
   int conflicts = 0;

   always #5 clk = ~clk;

   pc_bus_host #(.READ_SETTLE(S)) dut (
      .clk(clk), .rst_n(rst_n), .run(run),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
      .ctrl_en(ctrl_en), .ctrl_load(ctrl_load), .ctrl_oe(ctrl_oe),
      .bus_out(bus_out), .bus_oe(bus_oe), .bus_in(bus_in)
   );

   // Counter model: controls registered one cycle late, capture two cycles
   // after the load edge is seen, drives the bus only when idle with oe.
   logic       en_q, load_q, load_qq, oe_q, arm1, arm2;
   logic [7:0] cnt;
   logic       busy, cnt_drv;

   assign busy    = load_q | arm1 | arm2;
   assign cnt_drv = oe_q & ~busy;
   assign bus_in  = bus_oe ? bus_out : (cnt_drv ? cnt : 8'h00);

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         en_q <= 1'b0; load_q <= 1'b0; load_qq <= 1'b0; oe_q <= 1'b0;
         arm1 <= 1'b0; arm2 <= 1'b0; cnt <= 8'h00;
      end else begin
         en_q    <= ctrl_en;
         load_q  <= ctrl_load;
         load_qq <= load_q;
         oe_q    <= ctrl_oe;
         arm1    <= load_q & ~load_qq;
         arm2    <= arm1;
         if (arm2)              cnt <= bus_in;
         else if (en_q && !busy) cnt <= cnt + 8'h01;
      end
   end

   always @(negedge clk) begin
      if (rst_n && bus_oe && cnt_drv) conflicts++;
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Entered at the falling edge of the acceptance cycle; returns at the
   // falling edge of the first idle cycle after the response.
   task automatic do_write(input logic [7:0] d, input logic [7:0] d_after,
                           input logic keep);
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_data = d;
      chk("wr_accept_ready", cmd_ready, 1);
      @(negedge clk); // T0
      cmd_valid = keep; cmd_data = d_after;
      chk("wr_t0_load", ctrl_load, 1);
      chk("wr_t0_oe", ctrl_oe, 0);
      chk("wr_t0_en", ctrl_en, 0);
      chk("wr_t0_bus_oe", bus_oe, 0);
      chk("wr_t0_ready", cmd_ready, 0);
      @(negedge clk); // T1
      chk("wr_t1_load", ctrl_load, 0);
      chk("wr_t1_oe", ctrl_oe, 0);
      chk("wr_t1_bus_oe", bus_oe, 0);
      chk("wr_t1_en", ctrl_en, 0);
      for (int t = 2; t <= 3; t++) begin
         @(negedge clk);
         chk("wr_drive_bus_oe", bus_oe, 1);
         chk("wr_drive_bus_out", bus_out, d);
         chk("wr_drive_oe", ctrl_oe, 0);
         chk("wr_drive_en", ctrl_en, 0);
         chk("wr_drive_load", ctrl_load, 0);
         chk("wr_drive_rsp", rsp_valid, 0);
      end
      @(negedge clk); // T4
      chk("wr_t4_bus_oe", bus_oe, 0);
      chk("wr_t4_oe", ctrl_oe, 1);
      chk("wr_t4_rsp_valid", rsp_valid, 1);
      chk("wr_t4_rsp_data", rsp_data, d);
      chk("wr_t4_en", ctrl_en, run);
      chk("wr_t4_ready", cmd_ready, 0);
      @(negedge clk); // T5
      chk("wr_t5_ready", cmd_ready, 1);
      chk("wr_t5_rsp_valid", rsp_valid, 0);
      chk("wr_t5_model_cnt", cnt, d);
   endtask

   task automatic do_read(output logic [7:0] got);
      logic [7:0] snap;
      snap = 8'h00;
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_data = 8'h77;
      chk("rd_accept_ready", cmd_ready, 1);
      @(negedge clk); // T0
      cmd_valid = 1'b0;
      chk("rd_t0_en", ctrl_en, 0);
      chk("rd_t0_oe", ctrl_oe, 1);
      chk("rd_t0_ready", cmd_ready, 0);
      for (int t = 1; t <= S; t++) begin
         @(negedge clk);
         if (t == 1) snap = cnt;
         chk("rd_wait_en", ctrl_en, 0);
         chk("rd_wait_oe", ctrl_oe, 1);
         chk("rd_wait_rsp", rsp_valid, 0);
         chk("rd_frozen_cnt", cnt, snap);
      end
      @(negedge clk); // T_{S+1}
      chk("rd_done_rsp_valid", rsp_valid, 1);
      chk("rd_done_rsp_data", rsp_data, snap);
      chk("rd_done_en", ctrl_en, run);
      got = rsp_data;
      @(negedge clk); // T_{S+2}
      chk("rd_after_rsp_valid", rsp_valid, 0);
      chk("rd_after_ready", cmd_ready, 1);
   endtask

   initial begin
      logic [7:0] rd;
      rst_n = 1'b0; run = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0;
      cmd_data = 8'h00;

      // Reset values
      repeat (2) @(negedge clk);
      chk("rst_ctrl_en", ctrl_en, 0);
      chk("rst_ctrl_load", ctrl_load, 0);
      chk("rst_ctrl_oe", ctrl_oe, 0);
      chk("rst_bus_oe", bus_oe, 0);
      chk("rst_bus_out", bus_out, 8'h00);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_data", rsp_data, 8'h00);
      chk("rst_ready", cmd_ready, 1);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_oe", ctrl_oe, 1);
      chk("post_rst_ready", cmd_ready, 1);
      chk("post_rst_en", ctrl_en, 0);

      // WRITE 0xA5 then READ it back, run=0
      do_write(8'hA5, 8'h5A, 1'b0);
      do_read(rd);
      chk("read_back_a5", rd, 8'hA5);

      // WRITE with run=1: count continues from the loaded value
      run = 1'b1;
      do_write(8'h3C, 8'h00, 1'b0);
      @(negedge clk);
      chk("run_cnt_3d", cnt, 8'h3D);
      @(negedge clk);
      chk("run_cnt_3e", cnt, 8'h3E);

      // Back-to-back WRITEs, cmd_valid held high
      run = 1'b0;
      do_write(8'hFF, 8'h00, 1'b1);
      do_write(8'h00, 8'h00, 1'b0);
      chk("b2b_model_cnt", cnt, 8'h00);

      // Snapshot across wrap: in-flight increment takes 0xFF to 0x00
      run = 1'b1;
      do_write(8'hFE, 8'hFE, 1'b0);
      do_read(rd);
      chk("wrap_snapshot", rd, 8'h00);

      // Reset in the middle of the drive window
      run = 1'b0;
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_data = 8'h5A;
      chk("mid_accept_ready", cmd_ready, 1);
      @(negedge clk); // T0
      cmd_valid = 1'b0;
      @(negedge clk); // T1
      @(negedge clk); // T2
      chk("mid_t2_bus_oe", bus_oe, 1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_bus_oe", bus_oe, 0);
      chk("mid_rst_oe", ctrl_oe, 0);
      chk("mid_rst_ready", cmd_ready, 1);
      chk("mid_rst_rsp", rsp_valid, 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("mid_rst_hold_rsp", rsp_valid, 0);
      end
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("mid_after_rsp", rsp_valid, 0);
         chk("mid_after_ready", cmd_ready, 1);
      end
      chk("mid_after_oe", ctrl_oe, 1);

      chk("bus_conflicts", conflicts, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pc_bus_host.md
# pc_bus_host

Sequencer that sits directly upstream of the 8-bit programmable counter and is its only master. It drives the counter's three control lines (`en`, `load`, `oe`) and shares the counter's bidirectional 8-bit bus. Two kinds of command arrive on a valid/ready port: WRITE loads a value into the counter, and READ returns a coherent snapshot of the count. The block schedules bus turnaround so that the host and the counter never drive the bus in the same cycle.

## Interface
- `READ_SETTLE`, default 2, range 1..15: cycles between freezing the counter and sampling `bus_in`.
- `clk` in 1: single clock; every register is rising-edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `run` in 1: free-run request, passed to `ctrl_en` while idle.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: command accepted at a rising edge where `cmd_valid & cmd_ready`.
- `cmd_write` in 1: 1 = WRITE, 0 = READ.
- `cmd_data` in 8: value to load (WRITE only).
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_data` out 8: READ returns the snapshot; WRITE echoes the loaded value.
- `ctrl_en` out 1: counter increment enable.
- `ctrl_load` out 1: counter load request; the counter acts on its rising edge.
- `ctrl_oe` out 1: counter output-enable request.
- `bus_out` out 8: host drive data.
- `bus_oe` out 1: host drive enable, active high.
- `bus_in` in 8: shared bus value.

## Operation
- States: IDLE, WR_LOAD, WR_GAP, WR_DRIVE (2 cycles), WR_DONE, RD_WAIT (`READ_SETTLE`+1 cycles), RD_DONE.
- `cmd_ready` is combinational and equals (state == IDLE). The command is captured at acceptance. `cmd_valid` outside IDLE is ignored.
- All `ctrl_*`, `bus_*` and `rsp_*` outputs are registered.
- Output values per state:
  - IDLE: `ctrl_en`=`run`, `ctrl_oe`=1, `ctrl_load`=0, `bus_oe`=0.
  - Every other state holds `ctrl_en`=0, except WR_DONE and RD_DONE, which set `ctrl_en`=`run`.
- Counter contract the schedule relies on:
  - The counter registers its controls one cycle late.
  - It captures `bus_in` two cycles after it sees the `load` edge.
  - It drives the bus only while idle with `oe` set.
- WRITE schedule, where T0 is the first cycle after acceptance:
  - T0 WR_LOAD: `ctrl_load`=1, `ctrl_oe`=0.
  - T1 WR_GAP: `ctrl_load`=0, `ctrl_oe`=0. Bus undriven; this is the turnaround cycle.
  - T2–T3 WR_DRIVE: `bus_oe`=1, `bus_out`=`cmd_data`. The counter captures at the end of T3.
  - T4 WR_DONE: `bus_oe`=0, `ctrl_oe`=1, `rsp_valid`=1, `rsp_data`=`cmd_data`.
  - T5: back in IDLE. The counter resumes driving the bus at T5 at the earliest, leaving one undriven cycle.
- READ schedule:
  - T0..T_S RD_WAIT, where S=`READ_SETTLE`: `ctrl_en`=0 and `ctrl_oe` stays 1. `bus_in` is sampled into `rsp_data` at the end of T_S.
  - T_{S+1} RD_DONE: `rsp_valid`=1 and `ctrl_en` is restored to `run`.
  - T_{S+2}: back in IDLE.
- The snapshot is the count after any increment that was already in flight at T0.
- Bus exclusivity invariant: `bus_oe`=1 only in WR_DRIVE. `ctrl_oe` has been 0 for at least 2 cycles before WR_DRIVE and stays 0 until after it.
- `ctrl_load` is high for exactly one cycle per WRITE. Back-to-back WRITEs therefore always present a fresh rising edge.

## Timing
- Reset values while `rst_n`=0: `ctrl_en`=0, `ctrl_load`=0, `ctrl_oe`=0, `bus_oe`=0, `bus_out`=0x00, `rsp_valid`=0, `rsp_data`=0x00, state IDLE (so `cmd_ready`=1).
- The first edge after reset release loads the IDLE output values.
- Reset mid-command is asynchronous: outputs go to their reset values immediately, the command is dropped and no `rsp_valid` is issued.
- Latency:
  - WRITE: acceptance edge to `rsp_valid` is 5 cycles; next acceptance at the earliest 6 cycles after the previous one.
  - READ: `rsp_valid` arrives `READ_SETTLE`+2 cycles after acceptance; next acceptance `READ_SETTLE`+3 cycles after.
- `run` changes during a command take effect in the DONE cycle.
- `cmd_data`/`cmd_write` changes after acceptance have no effect.

## Test plan
- **Reset values:** reset asserted, then released with `run`=0 → all outputs hold reset values during reset; one edge after release `ctrl_oe`=1, `cmd_ready`=1 and `ctrl_en`=0.
- **WRITE then READ:** WRITE 0xA5 with `run`=0, then READ against a counter model →
  - WRITE: `ctrl_load` pulses at T0, `bus_oe` is high for exactly T2–T3 with `bus_out`=0xA5, `rsp_valid` at T4 with 0xA5.
  - READ: `rsp_data`=0xA5, `rsp_valid` 4 cycles after acceptance.
- **WRITE with `run`=1:** WRITE 0x3C with `run`=1 → counter model reads 0x3C after capture, then 0x3D, 0x3E…; `ctrl_en`=0 from T0 to T3.
- **Bus exclusivity:** back-to-back WRITEs 0xFF, 0x00 with `cmd_valid` held high → second acceptance 6 cycles after the first; the model reads 0x00; no cycle has both `bus_oe`=1 and the counter driving.
- **Snapshot coherence:** READ with `run`=1 while the counter wraps through 0xFF→0x00 → `rsp_data` equals the model count at sample time; the count is unchanged between T1 and T_S.
- **Reset mid-WRITE:** assert `rst_n`=0 in T2 with `bus_oe`=1 → `bus_oe`=0 and `ctrl_oe`=0 immediately; no `rsp_valid`; `cmd_ready`=1.
